// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-granular arbiter that shares one UART
//               TX byte engine among NUM_REQ byte-stream requesters. A grant
//               is held until the packet's last byte has been shifted out or
//               the requester stays idle for MAX_GAP cycles mid-packet.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_GAP = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          pkt_abort
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(MAX_GAP - 1);
  localparam logic [ID_W-1:0]  C_PTR_RST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Registered state
  state_t              r_state;
  logic                r_grant_vld;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     r_ptr;
  logic                r_tx_start;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_last;
  logic [GAP_W-1:0]    r_gap;
  logic                r_abort;

  // Next-state values
  state_t              w_state;
  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_ptr;
  logic                w_tx_start;
  logic [DATA_W-1:0]   w_tx_data;
  logic                w_last;
  logic [GAP_W-1:0]    w_gap;
  logic                w_abort;

  // Arbitration and granted-stream views
  logic                w_arb_found;
  logic [ID_W-1:0]     w_arb_idx;
  logic [ID_W-1:0]     w_scan_idx;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_accept;

  // Round-robin scan starting just after the last owner; the lowest offset
  // wins, so scanning from the far end and overwriting leaves the nearest.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan_idx  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_scan_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (req_valid[w_scan_idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_scan_idx;
      end
    end
  end

  // Only the owner's lines matter while a grant is held.
  always_comb begin
    w_sel_valid = req_valid[r_grant_id];
    w_sel_last  = req_last[r_grant_id];
    w_sel_data  = req_data[r_grant_id*DATA_W +: DATA_W];
    w_accept    = (r_state == ST_SEND) && w_sel_valid && !tx_busy;
  end

  // One-hot byte accept, only in SEND and only while the engine is free.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[r_grant_id] = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state     = r_state;
    w_grant_vld = r_grant_vld;
    w_grant_id  = r_grant_id;
    w_ptr       = r_ptr;
    w_tx_start  = 1'b0;
    w_tx_data   = r_tx_data;
    w_last      = r_last;
    w_gap       = r_gap;
    w_abort     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_grant_id  = w_arb_idx;
          w_grant_vld = 1'b1;
          w_gap       = '0;
          w_state     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (w_accept) begin
          w_tx_data  = w_sel_data;
          w_tx_start = 1'b1;
          w_last     = w_sel_last;
          w_gap      = '0;
          w_state    = ST_WAIT_ACK;
        end else if (!w_sel_valid && !tx_busy) begin
          // Gap timer only runs while the engine could take a byte.
          if (r_gap == C_GAP_LAST) begin
            w_abort     = 1'b1;
            w_grant_vld = 1'b0;
            w_ptr       = r_grant_id;
            w_gap       = '0;
            w_state     = ST_IDLE;
          end else begin
            w_gap = r_gap + 1'b1;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (tx_busy) begin
          w_state = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last) begin
            // Releasing owner becomes lowest priority next round.
            w_ptr       = r_grant_id;
            w_grant_vld = 1'b0;
            w_state     = ST_IDLE;
          end else begin
            w_state = ST_SEND;
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_ptr       <= C_PTR_RST;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_gap       <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_grant_vld <= w_grant_vld;
      r_grant_id  <= w_grant_id;
      r_ptr       <= w_ptr;
      r_tx_start  <= w_tx_start;
      r_tx_data   <= w_tx_data;
      r_last      <= w_last;
      r_gap       <= w_gap;
      r_abort     <= w_abort;
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign grant_vld = r_grant_vld;
  assign grant_id  = r_grant_id;
  assign pkt_abort = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a TX engine
//               model, queue-based requesters and a packet-level
//               round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 64;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DW-1:0]        tx_data;
  logic                 tx_busy = 1'b0;
  logic                 grant_vld;
  logic [IDW-1:0]       grant_id;
  logic                 pkt_abort;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MAX_GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .pkt_abort (pkt_abort)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester byte streams and expected transmit order
  logic [DW-1:0]   byte_q[NREQ][$];
  logic            last_q[NREQ][$];
  int              gap_r[NREQ];
  int              gap_max = 0;
  logic [NREQ-1:0] acc_snap = '0;
  int              e_id[$];
  logic [DW-1:0]   e_byte[$];

  // Engine model and event counters
  int busy_cnt = 0;
  bit force_busy = 1'b0;
  int cyc = 0, fall_cyc = 0, abort_dist = 0;
  int abort_cnt = 0, start_cnt = 0, ready_cnt = 0;
  int wn;

  // Per-cycle: retire accepted bytes, run the TX engine, drive requesters.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_snap[i] && byte_q[i].size() != 0) begin
        void'(byte_q[i].pop_front());
        if (last_q[i].pop_front()) gap_r[i] = 0;
        else gap_r[i] = $urandom_range(gap_max, 0);
      end
    end

    if (tx_start === 1'b1) begin
      start_cnt++;
      check_eq("start_busy_low", tx_busy, 0);
      check_eq("start_expected", e_id.size() != 0, 1);
      if (e_id.size() != 0) begin
        check_eq("tx_id", grant_id, e_id.pop_front());
        check_eq("tx_data", tx_data, e_byte.pop_front());
      end
      tx_busy  = 1'b1;
      busy_cnt = $urandom_range(6, 1);
    end else if (force_busy) begin
      tx_busy = 1'b1;
    end else if (tx_busy) begin
      if (busy_cnt <= 1) begin
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end else begin
        busy_cnt--;
      end
    end

    if (pkt_abort === 1'b1) begin
      abort_cnt++;
      abort_dist = cyc - fall_cyc;
      check_eq("abort_grant_drop", grant_vld, 0);
    end

    for (int i = 0; i < NREQ; i++) begin
      if (gap_r[i] > 0) gap_r[i]--;
      req_valid[i] = (byte_q[i].size() != 0) && (gap_r[i] == 0);
      req_data[i*DW +: DW] = (byte_q[i].size() != 0) ? byte_q[i][0] : '0;
      req_last[i] = (byte_q[i].size() != 0) ? last_q[i][0] : 1'b0;
    end

    #2;
    acc_snap = reset ? '0 : (req_ready & req_valid);
    if (req_ready != '0) ready_cnt++;
    check_eq("ready_onehot", $countones(req_ready) <= 1, 1);
    check_eq("ready_while_busy", (|req_ready) && tx_busy, 0);
    if (|req_ready) begin
      check_eq("ready_owner", req_ready, 32'(1) << grant_id);
      check_eq("ready_granted", grant_vld, 1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input int r, input logic [DW-1:0] b, input logic l);
    byte_q[r].push_back(b);
    last_q[r].push_back(l);
  endtask

  task automatic exp_push(input int r, input logic [DW-1:0] b);
    e_id.push_back(r);
    e_byte.push_back(b);
  endtask

  task automatic clear_streams();
    for (int i = 0; i < NREQ; i++) begin
      byte_q[i].delete();
      last_q[i].delete();
      gap_r[i] = 0;
    end
    e_id.delete();
    e_byte.delete();
  endtask

  task automatic do_reset();
    clear_streams();
    force_busy = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    abort_cnt = 0;
    start_cnt = 0;
    ready_cnt = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((e_id.size() != 0 || grant_vld || tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, e_id.size(), 0);
    check_eq({tag, "_idle"}, grant_vld, 0);
  endtask

  // Packet-level reference: each round the first requester after the
  // previous owner with a pending packet sends that whole packet.
  task automatic load_random();
    int plen[NREQ][$];
    int off[NREQ];
    int ptr = NREQ - 1;
    int left = 0;
    for (int r = 0; r < NREQ; r++) begin
      int np;
      np = $urandom_range(4, 0);
      off[r] = 0;
      for (int p = 0; p < np; p++) begin
        int len;
        len = $urandom_range(4, 1);
        plen[r].push_back(len);
        left++;
        for (int b = 0; b < len; b++) push_byte(r, DW'($urandom), b == len - 1);
      end
    end
    while (left > 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int r;
        r = (ptr + k) % NREQ;
        if (plen[r].size() != 0) begin
          int len;
          len = plen[r].pop_front();
          for (int b = 0; b < len; b++) exp_push(r, byte_q[r][off[r] + b]);
          off[r] += len;
          ptr = r;
          left--;
          break;
        end
      end
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_grant_vld", grant_vld, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_pkt_abort", pkt_abort, 0);

    // One 3-byte packet from requester 2
    push_byte(2, 8'hA1, 1'b0);
    push_byte(2, 8'hA2, 1'b0);
    push_byte(2, 8'hA3, 1'b1);
    exp_push(2, 8'hA1);
    exp_push(2, 8'hA2);
    exp_push(2, 8'hA3);
    drain("t1", 200);
    check_eq("t1_starts", start_cnt, 3);

    // Single-byte packets on 0,1,3 rotate in round-robin order
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_byte(0, 8'h10 + 8'(k), 1'b1);
      push_byte(1, 8'h20 + 8'(k), 1'b1);
      push_byte(3, 8'h30 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      exp_push(0, 8'h10 + 8'(k));
      exp_push(1, 8'h20 + 8'(k));
      exp_push(3, 8'h30 + 8'(k));
    end
    drain("t2", 300);
    check_eq("t2_starts", start_cnt, 6);

    // No preemption: requester 0 arrives while requester 1 owns the engine
    do_reset();
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    wn = 0;
    while (!(grant_vld && grant_id == 2'd1) && wn < 20) begin tick(); wn++; end
    check_eq("t3_owner", grant_id, 1);
    push_byte(0, 8'h50, 1'b1);
    exp_push(1, 8'h41);
    exp_push(1, 8'h42);
    exp_push(1, 8'h43);
    exp_push(0, 8'h50);
    drain("t3", 300);

    // Gap timeout on requester 3 after its first byte
    do_reset();
    push_byte(3, 8'h61, 1'b0);
    wn = 0;
    while (!(grant_vld && grant_id == 2'd3) && wn < 20) begin tick(); wn++; end
    check_eq("t4_owner", grant_id, 3);
    push_byte(0, 8'h62, 1'b1);
    exp_push(3, 8'h61);
    exp_push(0, 8'h62);
    drain("t4", 400);
    check_eq("t4_aborts", abort_cnt, 1);
    check_eq("t4_abort_delay", abort_dist, GAP + 1);
    check_eq("t4_starts", start_cnt, 2);

    // Reset while the engine is shifting a byte
    do_reset();
    push_byte(2, 8'h71, 1'b0);
    push_byte(2, 8'h72, 1'b1);
    exp_push(2, 8'h71);
    wn = 0;
    while (!tx_busy && wn < 20) begin tick(); wn++; end
    force_busy = 1'b1;
    tick();
    check_eq("t5_in_frame", tx_data, 8'h71);
    clear_streams();
    reset = 1'b1;
    tick();
    check_eq("t5_tx_start", tx_start, 0);
    check_eq("t5_tx_data", tx_data, 0);
    check_eq("t5_req_ready", req_ready, 0);
    check_eq("t5_grant_vld", grant_vld, 0);
    check_eq("t5_grant_id", grant_id, 0);
    check_eq("t5_pkt_abort", pkt_abort, 0);
    reset = 1'b0;
    force_busy = 1'b0;
    push_byte(1, 8'h73, 1'b1);
    push_byte(0, 8'h74, 1'b1);
    exp_push(0, 8'h74);
    exp_push(1, 8'h73);
    drain("t5", 300);

    // Engine held busy for 500 cycles
    do_reset();
    force_busy = 1'b1;
    push_byte(0, 8'h81, 1'b1);
    exp_push(0, 8'h81);
    tick(500);
    check_eq("t6_ready", ready_cnt, 0);
    check_eq("t6_start", start_cnt, 0);
    check_eq("t6_abort", abort_cnt, 0);
    check_eq("t6_granted", grant_vld, 1);
    force_busy = 1'b0;
    drain("t6", 100);

    // Randomized packets with short mid-packet gaps
    for (int round = 0; round < 8; round++) begin
      do_reset();
      gap_max = 3;
      load_random();
      drain("rnd", 4000);
      check_eq("rnd_aborts", abort_cnt, 0);
    end
    gap_max = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
